// File: rtl/aes_round_ctrl_if.sv
// Host/datapath handshake bundle for aes_round_ctrl.
// AES_CTRL_DEC_EN adds the dec_i direction select.
interface aes_round_ctrl_if #(
  parameter int CNT_W = 4
);
`ifdef AES_CTRL_DEC_EN
  logic             dec_i;
`endif
  logic             start_i;
  logic [1:0]       key_len_i;
  logic             stall_i;
  logic             ack_i;
  logic             ready_o;
  logic             load_o;
  logic             step_o;
  logic             round_sel_o;
  logic             mix_en_o;
  logic [CNT_W-1:0] round_o;
  logic             done_o;
  logic             err_o;

  modport master (
`ifdef AES_CTRL_DEC_EN
    output dec_i,
`endif
    output start_i, key_len_i, stall_i, ack_i,
    input  ready_o, load_o, step_o, round_sel_o, mix_en_o, round_o, done_o, err_o
  );

  modport slave (
`ifdef AES_CTRL_DEC_EN
    input  dec_i,
`endif
    input  start_i, key_len_i, stall_i, ack_i,
    output ready_o, load_o, step_o, round_sel_o, mix_en_o, round_o, done_o, err_o
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: IDLE -> LOAD -> ROUND -> FINAL -> DONE, 10/12/14 rounds.
// Optional AES_CTRL_DEC_EN build: round_o counts down for decryption.
module aes_round_ctrl #(
  parameter int NR128 = 10,
  parameter int NR192 = 12,
  parameter int NR256 = 14,
  parameter int CNT_W = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  aes_round_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] nr_q, nr_d;
  logic             err_q, err_d;
  logic             dec_q, dec_d;
  logic [CNT_W-1:0] nr_sel;
  logic             dec_in;
  logic             active;

`ifdef AES_CTRL_DEC_EN
  assign dec_in = bus.dec_i;
`else
  assign dec_in = 1'b0;
`endif

  always_comb begin
    nr_sel = CNT_W'(NR128);
    case (bus.key_len_i)
      2'b01:   nr_sel = CNT_W'(NR192);
      2'b10:   nr_sel = CNT_W'(NR256);
      default: nr_sel = CNT_W'(NR128);
    endcase
  end

  // Counter tracks the forward round index; FINAL holds it at nr.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nr_d    = nr_q;
    err_d   = 1'b0;
    dec_d   = dec_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          if (bus.key_len_i == 2'b11) begin
            err_d = 1'b1;
          end else begin
            nr_d    = nr_sel;
            cnt_d   = '0;
            dec_d   = dec_in;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (!bus.stall_i) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (!bus.stall_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == nr_q - 1'b1) state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        if (!bus.stall_i) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nr_q    <= CNT_W'(NR128);
      err_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nr_q    <= nr_d;
      err_q   <= err_d;
      dec_q   <= dec_d;
    end
  end

  assign active = (state_q == S_LOAD) || (state_q == S_ROUND) || (state_q == S_FINAL);

  always_comb begin
    bus.ready_o     = (state_q == S_IDLE);
    bus.load_o      = (state_q == S_LOAD);
    bus.step_o      = active && !bus.stall_i;
    bus.round_sel_o = (state_q == S_ROUND) || (state_q == S_FINAL);
    bus.mix_en_o    = (state_q == S_ROUND);
    bus.done_o      = (state_q == S_DONE);
    bus.err_o       = err_q;
    bus.round_o     = '0;
    // Decrypt walks the key schedule backwards: nr at LOAD, 0 at FINAL.
    if (active) bus.round_o = dec_q ? (nr_q - cnt_q) : cnt_q;
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed + randomized check of aes_round_ctrl against a slot-based round model.
// Honours AES_CTRL_DEC_EN when the bundle is built with it.
module tb_aes_round_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  aes_round_ctrl_if #(.CNT_W(CNT_W)) bus ();

  aes_round_ctrl #(.NR128(10), .NR192(12), .NR256(14), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ready"}, 32'(bus.ready_o), 1);
    chk({tag, ".load"},  32'(bus.load_o), 0);
    chk({tag, ".step"},  32'(bus.step_o), 0);
    chk({tag, ".rsel"},  32'(bus.round_sel_o), 0);
    chk({tag, ".mix"},   32'(bus.mix_en_o), 0);
    chk({tag, ".round"}, 32'(bus.round_o), 0);
    chk({tag, ".done"},  32'(bus.done_o), 0);
    chk({tag, ".err"},   32'(bus.err_o), 0);
  endtask

  function automatic int nr_of(input int kl);
    return (kl == 0) ? 10 : (kl == 1) ? 12 : 14;
  endfunction

  task automatic set_dec(input bit d);
`ifdef AES_CTRL_DEC_EN
    bus.dec_i = d;
`else
    if (d) $display("note: dec requested in encrypt-only build");
`endif
  endtask

  // Model: a block is nr+1 datapath slots (0=load, 1..nr-1 mixed rounds,
  // nr=final); a stalled cycle repeats its slot. DONE follows the last slot.
  // mode: 0 no stall, 1 three stalls on slot 5, 2 random stalls.
  task automatic run_block(input int kl, input bit dec, input int mode, input int ack_wait);
    int nr, slot, stalled, exp_round;
    bit st;
    nr = nr_of(kl);
    bus.start_i = 1'b1;
    bus.key_len_i = 2'(kl);
    set_dec(dec);
    bus.stall_i = 1'b0;
    bus.ack_i = 1'b0;
    #4;
    chk("idle.ready", 32'(bus.ready_o), 1);
    step();
    slot = 0;
    stalled = 0;
    while (slot <= nr) begin
      // start_i/key_len_i/dec_i noise while busy must have no effect
      bus.start_i = 1'($urandom);
      bus.key_len_i = 2'($urandom);
      set_dec(dec ^ 1'($urandom));
      st = 1'b0;
      if (mode == 1) st = (slot == 5) && (stalled < 3);
      if (mode == 2) st = ($urandom_range(0, 3) == 0);
      bus.stall_i = st;
      #4;
      exp_round = dec ? nr - slot : slot;
      chk($sformatf("blk.load.s%0d", slot), 32'(bus.load_o), (slot == 0) ? 1 : 0);
      chk($sformatf("blk.rsel.s%0d", slot), 32'(bus.round_sel_o), (slot > 0) ? 1 : 0);
      chk($sformatf("blk.mix.s%0d", slot), 32'(bus.mix_en_o), (slot > 0 && slot < nr) ? 1 : 0);
      chk($sformatf("blk.round.s%0d", slot), 32'(bus.round_o), 32'(exp_round));
      chk($sformatf("blk.step.s%0d", slot), 32'(bus.step_o), st ? 0 : 1);
      chk("blk.ready", 32'(bus.ready_o), 0);
      chk("blk.done", 32'(bus.done_o), 0);
      step();
      if (st) stalled++;
      else slot++;
    end
    for (int w = 0; w < ack_wait; w++) begin
      bus.start_i = 1'b1;
      bus.key_len_i = 2'b00;
      bus.stall_i = 1'($urandom);
      #4;
      chk("done.done", 32'(bus.done_o), 1);
      chk("done.ready", 32'(bus.ready_o), 0);
      chk("done.step", 32'(bus.step_o), 0);
      step();
    end
    bus.start_i = 1'b0;
    bus.ack_i = 1'b1;
    #4;
    chk("ack.done", 32'(bus.done_o), 1);
    step();
    bus.ack_i = 1'b0;
    bus.stall_i = 1'b0;
    #4;
    chk("post.ready", 32'(bus.ready_o), 1);
    chk("post.done", 32'(bus.done_o), 0);
  endtask

  initial begin
    bit can_dec;
`ifdef AES_CTRL_DEC_EN
    can_dec = 1'b1;
`else
    can_dec = 1'b0;
`endif
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.key_len_i = 2'b00;
    bus.stall_i = 1'b0;
    bus.ack_i = 1'b0;
    set_dec(1'b0);
    step();
    chk_reset_vals("rst");
    step();
    rst = 1'b0;
    #4;
    chk_reset_vals("idle");

    // AES-128/192/256, no stall
    run_block(0, 1'b0, 0, 0);
    run_block(1, 1'b0, 0, 0);
    run_block(2, 1'b0, 0, 0);
    // stall during round 5, then held DONE with start noise
    run_block(0, 1'b0, 1, 0);
    run_block(0, 1'b0, 0, 5);
    if (can_dec) run_block(0, 1'b1, 0, 0);

    // illegal key length: one-cycle err pulse, remains idle
    bus.start_i = 1'b1;
    bus.key_len_i = 2'b11;
    #4;
    chk("ill.ready0", 32'(bus.ready_o), 1);
    step();
    bus.start_i = 1'b0;
    #4;
    chk("ill.err", 32'(bus.err_o), 1);
    chk("ill.ready", 32'(bus.ready_o), 1);
    chk("ill.load", 32'(bus.load_o), 0);
    step();
    #4;
    chk("ill.err_clr", 32'(bus.err_o), 0);
    chk("ill.idle", 32'(bus.ready_o), 1);

    // async reset in round 4
    bus.start_i = 1'b1;
    bus.key_len_i = 2'b00;
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("abort.pre_round", 32'(bus.round_o), 4);
    #1 rst = 1'b1;
    #1;
    chk_reset_vals("abort");
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #4;
      chk("abort.nodone", 32'(bus.done_o), 0);
      step();
    end

    // randomized blocks
    for (int b = 0; b < 12; b++) begin
      run_block($urandom_range(0, 2), can_dec & 1'($urandom), 2, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
